// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one clocked two-operand datapath between two requesters.
// Operands go out registered; the result is captured after a fixed latency and returned with the requester ID.
module logic_unit_arbiter #(
    parameter int WIDTH      = 8,
    parameter int OP_W       = 2,
    parameter int DP_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [OP_W-1:0]  dp_op,
    input  logic [WIDTH-1:0] dp_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(DP_LATENCY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic [OP_W-1:0]  dp_op_q, dp_op_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             grant_s;
    logic             idle_s;
    logic             accept_s;

    // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Readys are gated by rst_n so nothing appears accepted while reset is held.
    assign idle_s     = (state_q == IDLE);
    assign req0_ready = rst_n & idle_s & req0_valid & ~grant_s;
    assign req1_ready = rst_n & idle_s & req1_valid & grant_s;
    assign accept_s   = req0_ready | req1_ready;

    // Next-state and datapath/response register updates.
    always_comb begin
        state_d      = state_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_op_d      = dp_op_q;
        rsp_y_d      = rsp_y_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    dp_a_d       = grant_s ? req1_a  : req0_a;
                    dp_b_d       = grant_s ? req1_b  : req0_b;
                    dp_op_d      = grant_s ? req1_op : req0_op;
                    rsp_id_d     = grant_s;
                    last_grant_d = grant_s;
                    cnt_d        = LAT_INIT;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_y_d     = dp_y;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dp_a_q       <= {WIDTH{1'b0}};
            dp_b_q       <= {WIDTH{1'b0}};
            dp_op_q      <= {OP_W{1'b0}};
            rsp_y_q      <= {WIDTH{1'b0}};
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            dp_op_q      <= dp_op_d;
            rsp_y_q      <= rsp_y_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_op     = dp_op_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = ~idle_s;

endmodule
